// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 response codes, the error data pattern used by
//                every error path in the node, and the R-side responder state
//                type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;

    // Filler word for error beats; the allocator's internal error path uses
    // the same word so that error data is recognisable wherever it comes from.
    localparam logic [31:0] ERR_DATA_WORD = 32'hDEADBEEF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_decerr_ar_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_decerr_ar_fifo
//  Description : Synchronous FIFO holding pending AR entries {id,len,user}.
//                The read data is the current head and is valid whenever
//                empty_o is low.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push_i/wdata_i - write strobe and entry
//                pop_i          - remove head
//                rdata_o        - head entry
//                full_o/empty_o - status flags
//                count_o        - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_decerr_ar_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra wrap bit on each pointer separates full from empty.
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic [PTR_W:0]   w_count;

    assign w_count = r_wptr - r_rptr;
    assign count_o = w_count;
    assign full_o  = (w_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (w_count == '0);
    assign rdata_o = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_i) begin
            r_mem[r_wptr[PTR_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (pop_i) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_r_decerr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_r_decerr_responder
//  Description : AXI4 read default slave. Accepts unmapped AR requests and
//                answers each with a full-length R burst carrying DECERR,
//                strictly in AR-accept order.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                arid_i..arvalid_i    - AR channel in, arready_o out
//                rid_o..rvalid_o      - R channel out, rready_i in
//                pending_o            - queued entries plus active burst
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_r_decerr_responder
    import axi_pkg::*;
#(
    parameter  int AXI_ID_W   = 20,
    parameter  int AXI_DATA_W = 64,
    parameter  int AXI_USER_W = 6,
    parameter  int DEPTH      = 4,
    localparam int PEND_W     = $clog2(DEPTH+2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_W-1:0]   arid_i,
    input  logic [7:0]            arlen_i,
    input  logic [AXI_USER_W-1:0] aruser_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [AXI_ID_W-1:0]   rid_o,
    output logic [AXI_DATA_W-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic [AXI_USER_W-1:0] ruser_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [PEND_W-1:0]     pending_o
);

    localparam int ENTRY_W = AXI_ID_W + 8 + AXI_USER_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    rd_state_e             r_state;
    rd_state_e             w_state_next;
    logic                  r_arready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [7:0]            r_len;
    logic [AXI_USER_W-1:0] r_user;
    logic [7:0]            r_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_in_burst;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [ENTRY_W-1:0]    w_head;

    assign w_push     = arvalid_i && r_arready;
    assign w_in_burst = (r_state == ST_BURST);
    assign w_beat     = w_in_burst && rready_i;
    assign w_last     = (r_cnt == r_len);
    // Load a new entry either from idle or straight after the last beat, so
    // back-to-back bursts run without a bubble.
    assign w_pop      = !w_fifo_empty && (!w_in_burst || (w_beat && w_last));

    axi_decerr_ar_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i ({arid_i, arlen_i, aruser_i}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // arready is registered from the FIFO occupancy after this cycle's
    // updates, so it never looks at rready and a pop frees a slot one cycle
    // later. A push never coincides with full because arready is low then.
    assign w_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arready <= 1'b1;
        end else begin
            r_arready <= (w_count_next != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_beat && w_last && w_fifo_empty) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Active burst registers; the beat counter restarts on every load so it
    // cannot wrap even for 256-beat bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= '0;
            r_len  <= '0;
            r_user <= '0;
            r_cnt  <= '0;
        end else if (w_pop) begin
            {r_id, r_len, r_user} <= w_head;
            r_cnt                 <= '0;
        end else if (w_beat && !w_last) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        rvalid_o = 1'b0;
        rid_o    = '0;
        ruser_o  = '0;
        rresp_o  = RESP_OKAY;
        rdata_o  = '0;
        rlast_o  = 1'b0;
        if (w_in_burst) begin
            rvalid_o = 1'b1;
            rid_o    = r_id;
            ruser_o  = r_user;
            rresp_o  = RESP_DECERR;
            rdata_o  = {(AXI_DATA_W/32){ERR_DATA_WORD}};
            rlast_o  = w_last;
        end
    end

    assign arready_o = r_arready;
    assign pending_o = PEND_W'(w_fifo_count) + {{(PEND_W-1){1'b0}}, w_in_burst};

    // Full status is implied by the registered arready; kept for visibility.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_axi_r_decerr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_r_decerr_responder
//  Description : Scoreboard bench for the DECERR read responder. AR requests
//                expand into expected beats; a negedge monitor compares every
//                R beat, the pending count, arready and R idle values against
//                a count-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_r_decerr_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] arid_i;
    logic [7:0]  arlen_i;
    logic [5:0]  aruser_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [19:0] rid_o;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic [5:0]  ruser_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [2:0]  pending_o;

    axi_r_decerr_responder #(
        .AXI_ID_W   (20),
        .AXI_DATA_W (64),
        .AXI_USER_W (6),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arid_i    (arid_i),
        .arlen_i   (arlen_i),
        .aruser_i  (aruser_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rlast_o   (rlast_o),
        .ruser_o   (ruser_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] id;
        logic [5:0]  user;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    pend  = 0;     // requests accepted but not fully answered
    bit    fresh = 1'b0;  // request just entered an empty responder
    bit    stalled = 1'b0;
    logic [19:0] h_id;
    logic [5:0]  h_user;
    logic        h_last;
    int    rready_mode = 1;  // 0 low, 1 high, 2 toggle, 3 random

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        beat_t e;
        bit    done;
        bit    ar_hs;
        done = 1'b0;
        if (rst) begin
            sb.delete();
            pend    = 0;
            fresh   = 1'b0;
            stalled = 1'b0;
        end else begin
            chk("pending", 64'(pending_o), 64'(pend));
            chk("arready", 64'(arready_o), 64'(pend != DEPTH + 1));
            chk("rvalid", 64'(rvalid_o), 64'((pend > 0) && !fresh));
            if (rvalid_o) begin
                if (stalled) begin
                    chk("hold_fields", 64'({rid_o, ruser_o, rlast_o}), 64'({h_id, h_user, h_last}));
                end
                if (rready_i) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'(rid_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("rid", 64'(rid_o), 64'(e.id));
                        chk("ruser", 64'(ruser_o), 64'(e.user));
                        chk("rlast", 64'(rlast_o), 64'(e.last));
                        chk("rresp", 64'(rresp_o), 64'(2'b11));
                        chk("rdata", rdata_o, 64'hDEADBEEF_DEADBEEF);
                        done = e.last;
                    end
                end
            end else begin
                chk("idle_zero", 64'(|{rdata_o, rresp_o, rlast_o, rid_o, ruser_o}), 64'd0);
            end
            stalled = rvalid_o && !rready_i;
            h_id    = rid_o;
            h_user  = ruser_o;
            h_last  = rlast_o;
            ar_hs   = arvalid_i && arready_o;
            fresh   = ar_hs && ((pend - int'(done)) == 0);
            pend    = pend + int'(ar_hs) - int'(done);
            if (ar_hs) begin
                for (int b = 0; b <= int'(arlen_i); b++) begin
                    e.id   = arid_i;
                    e.user = aruser_i;
                    e.last = (b == int'(arlen_i));
                    sb.push_back(e);
                end
            end
        end
    end

    // R-ready driver.
    initial begin
        rready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rready_mode)
                0:       rready_i = 1'b0;
                1:       rready_i = 1'b1;
                2:       rready_i = ~rready_i;
                default: rready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_ar(input logic [19:0] id, input logic [7:0] len, input logic [5:0] user);
        int n;
        arvalid_i = 1'b1;
        arid_i    = id;
        arlen_i   = len;
        aruser_i  = user;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready_o) break;
            n++;
            if (n > 3000) begin
                chk("ar_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        arvalid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (pend != 0 || sb.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 5000) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        arvalid_i = 1'b0;
        arid_i    = '0;
        arlen_i   = '0;
        aruser_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat.
        rready_mode = 1;
        send_ar(20'h5, 8'd0, 6'h01);
        wait_drain();

        // Burst under alternating backpressure.
        rready_mode = 2;
        send_ar(20'h9, 8'd3, 6'h12);
        wait_drain();

        // Back-to-back requests, no bubble expected between bursts.
        rready_mode = 1;
        send_ar(20'h1, 8'd1, 6'h21);
        send_ar(20'h2, 8'd0, 6'h22);
        send_ar(20'h3, 8'd2, 6'h23);
        wait_drain();

        // Fill: four queued plus one active.
        rready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            send_ar(20'h10 + 20'(i), 8'(i), 6'(i));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_pending", 64'(pending_o), 64'd5);
        chk("full_arready", 64'(arready_o), 64'd0);
        @(posedge clk);
        #1;
        rready_mode = 1;
        send_ar(20'h15, 8'd2, 6'h15);
        wait_drain();

        // Maximum length, then a single-beat burst.
        send_ar(20'hABCDE, 8'd255, 6'h3F);
        send_ar(20'h7, 8'd0, 6'h07);
        wait_drain();

        // Reset while beat 2 of an 8-beat burst is presented.
        send_ar(20'h42, 8'd7, 6'h02);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_pending", 64'(pending_o), 64'd0);
        @(posedge clk);
        #1;
        send_ar(20'h43, 8'd1, 6'h03);
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            rready_mode = (i % 50 < 25) ? 3 : 1;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_ar(20'($urandom), 8'($urandom_range(0, 15)), 6'($urandom));
        end
        rready_mode = 1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
